alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/operand-issue stage directly upstream of the 16-bit ALU. It owns the 8-entry register file, which holds one LENGTH-bit word per entry.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them. It registers aluOpcode/data0/data1 into the ALU one cycle later.
- On the following edge it writes the ALU result back into the register file and forwards it to a dependent instruction in the same cycle.

Parameters:
- LENGTH, 16, datapath and register width; must be ≥ 16.
- NREGS, 8, number of registers; fixed by the 3-bit register fields.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instr holds a valid instruction.
- instr_ready  output  1  stage accepts instr this cycle; equals ~stall.
- instr  input  16  instruction word.
- stall  input  1  downstream hold; forces a bubble into the ALU.
- alu_opcode  output  3  registered; drives the ALU aluOpcode.
- alu_data0  output  LENGTH  registered; drives the ALU data0.
- alu_data1  output  LENGTH  registered; drives the ALU data1.
- alu_result  input  LENGTH  ALU alu_o (combinational, same cycle).
- wb_valid  output  1  combinational; high while a valid op is in EX.
- wb_rd  output  3  EX destination register.
- wb_data  output  LENGTH  equals alu_result.
- dbg_addr  input  3  debug read address.
- dbg_data  output  LENGTH  combinational regfile read; pre-writeback value.
- retire_count  output  16  number of ops written back; wraps.

Behaviour:
- Instruction encoding:
  - [15:13] op: 0 LHI, 1 LLI, 2 ADD, 3 ADC, 4 SUB, 5 SBB, 6 MOV, 7 NOP.
  - [12:10] rd, [9:7] rs, [6:4] rt, [7:0] imm8.
- Operand select by op:
  - LHI: data0 = R[rd], data1 = zero-extended imm8. The ALU produces {imm8, R[rd][7:0]}.
  - LLI: data0 = 0, data1 = imm8.
  - ADD/ADC/SUB/SBB: data0 = R[rs], data1 = R[rt].
  - MOV: data0 = R[rs], data1 = 0.
- Accept: a transfer occurs when instr_valid & instr_ready. NOP transfers are consumed but never enter EX as valid.
- EX register (one stage):
  - On an accepted non-NOP op: ex_valid <= 1, load alu_opcode/alu_data0/alu_data1/ex_rd.
  - Otherwise (no transfer, NOP, or stall=1): ex_valid <= 0, alu_opcode <= MOV (6), alu_data0 <= 0, alu_data1 <= 0.
  - EX never holds a previous op, because the ALU updates flags every clock.
- Bubble side effect (decided behaviour): an idle cycle drives MOV 0, so the ALU flags become N=0, Z=1, C=0, V=0. ADC/SBB consume the carry only from the immediately preceding cycle; software must issue them back-to-back with their producer.
- Writeback:
  - On every edge with ex_valid=1: R[ex_rd] <= alu_result, retire_count += 1 (wraps 0xFFFF→0).
  - wb_valid = ex_valid.
- Forwarding:
  - While decoding, any source (rs, rt, or rd for LHI) equal to ex_rd with ex_valid=1 takes alu_result instead of the regfile value.
  - The forwarded value is the one written back at that same edge.
  - No stall is ever needed for data hazards; latency is 1 cycle issue→ALU.
- stall=1: instr_ready=0 and EX loads a bubble. An op already in EX still writes back at that edge.
- dbg_data = R[dbg_addr] before the edge. Reading a register being written this cycle returns the old value.
- Reset, including mid-operation:
  - All R[i] = 0, ex_valid = 0, alu_opcode = MOV, alu_data0/alu_data1 = 0, retire_count = 0.
  - An in-flight EX op is discarded without writeback.
  - instr_ready = ~stall; it does not depend on reset.
- Throughput: one instruction per cycle when stall=0.

Test Plan:
- LLI R1,0x34 then LHI R1,0x12 back-to-back → the LHI data0 is forwarded as 0x0034. Next cycle dbg_addr=1 gives dbg_data=0x1234; retire_count=2.
- R2=0xFFFF, R3=0x0001: ADD R4,R2,R3 then ADC R5,R3,R3 back-to-back → R4=0x0000 (C=1); R5=0x0003.
- Same as above but with one idle cycle between ADD and ADC → R5=0x0002, because the bubble cleared carry.
- ADD R1,R1,R1 ×3 from R1=0x0001 with no gaps → forwarding chain gives R1=0x0008; wb_valid high for 3 consecutive cycles.
- stall=1 while instr_valid=1 with SUB R6,R2,R3 → instr_ready=0, alu_opcode=6, data=0, wb_valid=0 next cycle. Releasing stall issues the SUB once; R6 = R2 − R3.
- Assert reset while an ADD is in EX → no writeback; all regs 0, retire_count=0, ex_valid=0. A NOP stream afterwards leaves retire_count at 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage feeding a 16-bit ALU: owns the register file,
// issues one op per cycle into a single EX register and writes the ALU result back.
module alu_issue_stage #(
    parameter int LENGTH = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              stall,
    output logic [2:0]        alu_opcode,
    output logic [LENGTH-1:0] alu_data0,
    output logic [LENGTH-1:0] alu_data1,
    input  logic [LENGTH-1:0] alu_result,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [LENGTH-1:0] wb_data,
    input  logic [2:0]        dbg_addr,
    output logic [LENGTH-1:0] dbg_data,
    output logic [15:0]       retire_count
);

    localparam logic [2:0] OP_LHI = 3'd0;
    localparam logic [2:0] OP_LLI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_ADC = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SBB = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;
    localparam logic [LENGTH-1:0] ZERO = {LENGTH{1'b0}};

    logic [LENGTH-1:0] regs_q [NREGS];
    logic [LENGTH-1:0] regs_d [NREGS];
    logic              ex_valid_q, ex_valid_d;
    logic [2:0]        ex_rd_q, ex_rd_d;
    logic [2:0]        alu_opcode_q, alu_opcode_d;
    logic [LENGTH-1:0] alu_data0_q, alu_data0_d;
    logic [LENGTH-1:0] alu_data1_q, alu_data1_d;
    logic [15:0]       retire_count_q, retire_count_d;

    logic [2:0]        op_s, rd_s, rs_s, rt_s;
    logic [LENGTH-1:0] imm_s, rd_val_s, rs_val_s, rt_val_s;
    logic              accept_s;

    assign op_s     = instr[15:13];
    assign rd_s     = instr[12:10];
    assign rs_s     = instr[9:7];
    assign rt_s     = instr[6:4];
    assign imm_s    = {{(LENGTH-8){1'b0}}, instr[7:0]};
    assign accept_s = instr_valid & ~stall;

    // The op in EX writes back at the coming edge, so a matching source reads alu_result.
    assign rd_val_s = (ex_valid_q && (ex_rd_q == rd_s)) ? alu_result : regs_q[rd_s];
    assign rs_val_s = (ex_valid_q && (ex_rd_q == rs_s)) ? alu_result : regs_q[rs_s];
    assign rt_val_s = (ex_valid_q && (ex_rd_q == rt_s)) ? alu_result : regs_q[rt_s];

    // Decode and operand select; anything not issued becomes a MOV-0 bubble.
    always_comb begin
        ex_valid_d   = 1'b0;
        ex_rd_d      = 3'd0;
        alu_opcode_d = OP_MOV;
        alu_data0_d  = ZERO;
        alu_data1_d  = ZERO;
        if (accept_s && (op_s != OP_NOP)) begin
            ex_valid_d   = 1'b1;
            ex_rd_d      = rd_s;
            alu_opcode_d = op_s;
            case (op_s)
                OP_LHI: begin
                    alu_data0_d = rd_val_s;
                    alu_data1_d = imm_s;
                end
                OP_LLI: begin
                    alu_data1_d = imm_s;
                end
                OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                    alu_data0_d = rs_val_s;
                    alu_data1_d = rt_val_s;
                end
                OP_MOV: begin
                    alu_data0_d = rs_val_s;
                end
                default: begin
                    alu_data0_d = ZERO;
                    alu_data1_d = ZERO;
                end
            endcase
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    // Writeback of the EX result and retirement counting.
    always_comb begin
        regs_d         = regs_q;
        retire_count_d = retire_count_q;
        if (ex_valid_q) begin
            regs_d[ex_rd_q] = alu_result;
            retire_count_d  = retire_count_q + 16'd1;
        end else begin
            retire_count_d = retire_count_q;
        end
    end

    // State registers; reset discards any in-flight EX op.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= ZERO;
            end
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= 3'd0;
            alu_opcode_q   <= OP_MOV;
            alu_data0_q    <= ZERO;
            alu_data1_q    <= ZERO;
            retire_count_q <= 16'd0;
        end else begin
            regs_q         <= regs_d;
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_data0_q    <= alu_data0_d;
            alu_data1_q    <= alu_data1_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign instr_ready  = ~stall;
    assign alu_opcode   = alu_opcode_q;
    assign alu_data0    = alu_data0_q;
    assign alu_data1    = alu_data1_q;
    assign wb_valid     = ex_valid_q;
    assign wb_rd        = ex_rd_q;
    assign wb_data      = alu_result;
    assign dbg_data     = regs_q[dbg_addr];
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU closes the loop, a directed vector
// table covers the forwarding/carry/stall/reset cases, then random traffic runs against a model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'hE000;
    logic        stall = 1'b0;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_data0, alu_data1, alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;
    logic [15:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.LENGTH(16), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .stall(stall), .alu_opcode(alu_opcode), .alu_data0(alu_data0),
        .alu_data1(alu_data1), .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: result is combinational, carry flag updates every clock.
    function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a, b,
                                           input logic cin);
        logic [16:0] r;
        case (op)
            3'd0:    r = {1'b0, b[7:0], a[7:0]};
            3'd1:    r = {1'b0, b};
            3'd2:    r = {1'b0, a} + {1'b0, b};
            3'd3:    r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            3'd4:    r = {(a < b), a - b};
            3'd5:    r = {({1'b0, a} < ({1'b0, b} + {16'd0, cin})), a - b - {15'd0, cin}};
            3'd6:    r = {1'b0, a};
            default: r = 17'd0;
        endcase
        return r;
    endfunction

    logic        flag_c = 1'b0;
    logic [16:0] alu_full;
    always_comb alu_full = alu_fn(alu_opcode, alu_data0, alu_data1, flag_c);
    assign alu_result = alu_full[15:0];
    always @(posedge clk) flag_c <= alu_full[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: committed registers plus the one result awaiting writeback.
    logic [15:0] m_reg [8];
    logic [15:0] m_ret;
    logic        m_known = 1'b0;
    logic        pend_v = 1'b0;
    logic [2:0]  pend_rd;
    logic [15:0] pend_val;
    logic        pend_c;

    task automatic cycle(input logic r, input logic v, input logic [15:0] ins,
                         input logic s, input logic [2:0] d);
        logic [2:0]  op, rd, rs, rt;
        logic [7:0]  imm;
        logic        cin;
        logic [16:0] sum;
        @(negedge clk);
        reset = r; instr_valid = v; instr = ins; stall = s; dbg_addr = d;
        #1;
        chk("instr_ready", instr_ready, !s);
        if (m_known) begin
            chk("wb_valid", wb_valid, pend_v);
            if (pend_v) begin
                chk("wb_rd", wb_rd, pend_rd);
                chk("wb_data", wb_data, pend_val);
            end
            chk("dbg_data", dbg_data, m_reg[d]);
            chk("retire_count", retire_count, m_ret);
        end
        if (r) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
            m_ret = 16'd0; pend_v = 1'b0; m_known = 1'b1;
        end else begin
            cin = pend_v ? pend_c : 1'b0;
            if (pend_v) begin
                m_reg[pend_rd] = pend_val;
                m_ret = m_ret + 16'd1;
            end
            op = ins[15:13]; rd = ins[12:10]; rs = ins[9:7]; rt = ins[6:4]; imm = ins[7:0];
            pend_v = v && !s && (op != 3'd7);
            pend_rd = rd; pend_c = 1'b0;
            case (op)
                3'd0: pend_val = {imm, m_reg[rd][7:0]};
                3'd1: pend_val = {8'h00, imm};
                3'd2: begin sum = m_reg[rs] + m_reg[rt]; pend_val = sum[15:0]; pend_c = sum[16]; end
                3'd3: begin sum = m_reg[rs] + m_reg[rt] + cin; pend_val = sum[15:0]; pend_c = sum[16]; end
                3'd4: begin pend_val = m_reg[rs] - m_reg[rt]; pend_c = m_reg[rs] < m_reg[rt]; end
                3'd5: begin
                    pend_val = m_reg[rs] - m_reg[rt] - cin;
                    pend_c = (32'(m_reg[rs]) < 32'(m_reg[rt]) + 32'(cin));
                end
                3'd6: pend_val = m_reg[rs];
                default: pend_val = 16'd0;
            endcase
        end
    endtask

    typedef struct {
        logic rst; logic vld; logic [15:0] ins; logic stl; logic [2:0] dbg;
        logic [3:0] chk; logic [15:0] e_dbg; logic [15:0] e_ret; logic e_wbv;
        logic [2:0] e_op; logic [15:0] e_d0; logic [15:0] e_d1;
    } vec_t;
    vec_t vq[$];

    task automatic row(input logic rst, vld, input logic [15:0] ins, input logic stl,
                       input logic [2:0] dbg, input logic [3:0] c, input logic [15:0] e_dbg,
                       input logic [15:0] e_ret, input logic e_wbv, input logic [2:0] e_op,
                       input logic [15:0] e_d0, input logic [15:0] e_d1);
        vec_t t;
        t.rst = rst; t.vld = vld; t.ins = ins; t.stl = stl; t.dbg = dbg; t.chk = c;
        t.e_dbg = e_dbg; t.e_ret = e_ret; t.e_wbv = e_wbv; t.e_op = e_op; t.e_d0 = e_d0; t.e_d1 = e_d1;
        vq.push_back(t);
    endtask

    function automatic logic [15:0] ri(input logic [2:0] op, rd, rs, rt);
        return {op, rd, rs, rt, 4'h0};
    endfunction
    function automatic logic [15:0] ii(input logic [2:0] op, rd, input logic [7:0] imm);
        return {op, rd, 2'b00, imm};
    endfunction

    localparam logic [15:0] NOP = 16'hE000;

    initial begin
        // chk bits: 0 dbg_data, 1 retire_count, 2 wb_valid, 3 ALU operands
        row(1, 0, NOP, 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 0, 4'b1111, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(1, 1, 8'h34), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(0, 1, 8'h12), 0, 0, 4'b0100, 16'h0, 16'd0, 1, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 1, 4'b1111, 16'h0034, 16'd1, 1, 3'd0, 16'h0034, 16'h0012);
        row(0, 0, NOP, 0, 1, 4'b1111, 16'h1234, 16'd2, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(1, 2, 8'hFF), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(0, 2, 8'hFF), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(1, 3, 8'h01), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(0, 3, 8'h00), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 4, 2, 3), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(3, 5, 3, 3), 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd2, 16'hFFFF, 16'h0001);
        row(0, 0, NOP, 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd3, 16'h0001, 16'h0001);
        row(0, 0, NOP, 0, 4, 4'b0011, 16'h0000, 16'd8, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 5, 4'b0011, 16'h0003, 16'd8, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 4, 2, 3), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(3, 5, 3, 3), 0, 0, 4'b1100, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd3, 16'h0001, 16'h0001);
        row(0, 0, NOP, 0, 5, 4'b0011, 16'h0002, 16'd10, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ii(1, 1, 8'h01), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 1, 1, 1), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 1, 1, 1), 0, 0, 4'b0100, 16'h0, 16'd0, 1, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 1, 1, 1), 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd2, 16'h0002, 16'h0002);
        row(0, 0, NOP, 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd2, 16'h0004, 16'h0004);
        row(0, 0, NOP, 0, 0, 4'b0110, 16'h0, 16'd14, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 1, 4'b0011, 16'h0008, 16'd14, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(4, 6, 2, 3), 1, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(4, 6, 2, 3), 0, 0, 4'b1100, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 0, 4'b1100, 16'h0, 16'd0, 1, 3'd4, 16'hFFFF, 16'h0001);
        row(0, 0, NOP, 0, 6, 4'b0011, 16'hFFFE, 16'd15, 0, 3'd6, 16'h0, 16'h0);
        row(0, 0, NOP, 0, 0, 4'b0110, 16'h0, 16'd15, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, ri(2, 7, 2, 3), 0, 0, 4'b0000, 16'h0, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(1, 0, NOP, 0, 0, 4'b0100, 16'h0, 16'd0, 1, 3'd6, 16'h0, 16'h0);
        row(0, 1, NOP, 0, 7, 4'b1111, 16'h0000, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, NOP, 0, 2, 4'b0011, 16'h0000, 16'd0, 0, 3'd6, 16'h0, 16'h0);
        row(0, 1, NOP, 0, 4, 4'b0111, 16'h0000, 16'd0, 0, 3'd6, 16'h0, 16'h0);

        foreach (vq[k]) begin
            cycle(vq[k].rst, vq[k].vld, vq[k].ins, vq[k].stl, vq[k].dbg);
            if (vq[k].chk[0]) chk($sformatf("tbl%0d_dbg", k), dbg_data, vq[k].e_dbg);
            if (vq[k].chk[1]) chk($sformatf("tbl%0d_retire", k), retire_count, vq[k].e_ret);
            if (vq[k].chk[2]) chk($sformatf("tbl%0d_wb_valid", k), wb_valid, vq[k].e_wbv);
            if (vq[k].chk[3]) begin
                chk($sformatf("tbl%0d_opcode", k), alu_opcode, vq[k].e_op);
                chk($sformatf("tbl%0d_data0", k), alu_data0, vq[k].e_d0);
                chk($sformatf("tbl%0d_data1", k), alu_data1, vq[k].e_d1);
            end
        end

        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(4) != 0), 16'($urandom),
                  ($urandom_range(4) == 0), 3'($urandom));
        end

        cycle(0, 0, NOP, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
